// File: rtl/spi_device_lite.sv
// spi_device_lite: SPI mode-0 device (MSB first, 8-bit frames) oversampled on clk_i.
// Optional RX FIFO ahead of the output register: define SPI_DEVICE_LITE_RX_FIFO_EN.
module spi_device_lite #(
   parameter logic [7:0]  TxIdleByte  = 8'hFF,
   parameter int unsigned RxFifoDepth = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       spi_sck_i,
   input  logic       spi_csb_i,
   input  logic       spi_sd_i,
   output logic       spi_sd_o,
   output logic       spi_sd_en_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       busy_o,
   output logic       tx_underrun_o,
   output logic       rx_overflow_o,
   output logic       abort_o
);
   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] sck_q, csb_q, sd_q;
   logic [7:0] tx_hold_q, shift_out_q, rx_shift_q, rx_data_q;
   logic       tx_full_q, byte_done_q, rx_valid_q;
   logic [2:0] bit_cnt_q;
   logic       tx_underrun_q, rx_overflow_q, abort_q;

   logic       sck_rise, sck_fall, csb_fall, csb_high;
   logic       do_load, rx_edge, tx_edge;
   logic       out_load, overflow_d;
   logic [7:0] out_data;

   // Bit 0 is the metastability flop, bit 1 the synchronised value, bit 2 its history.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_q <= '0;
         csb_q <= '0;
         sd_q  <= '0;
      end else begin
         // NOTE: non-blocking so each stage takes its neighbour's pre-edge value; blocking would collapse the chain.
         sck_q <= {sck_q[1:0], spi_sck_i};
         csb_q <= {csb_q[1:0], spi_csb_i};
         sd_q  <= {sd_q[1:0], spi_sd_i};
      end
   end

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign csb_fall = ~csb_q[1] & csb_q[2];
   assign csb_high = csb_q[1];

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (csb_fall) state_d = LOAD;
         LOAD:    state_d = SHIFT;
         SHIFT:   if (sck_rise && (bit_cnt_q == 3'd7)) state_d = LOAD;
         default: state_d = IDLE;
      endcase
      if (csb_high) state_d = IDLE;
   end

   assign do_load = (state_q == LOAD) && !csb_high;
   assign rx_edge = (state_q == SHIFT) && !csb_high && sck_rise;
   // The falling edge that follows a completed byte belongs to the next frame's bit 7.
   assign tx_edge = (state_q == SHIFT) && !csb_high && sck_fall && (bit_cnt_q != 3'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         tx_hold_q     <= '0;
         tx_full_q     <= 1'b0;
         shift_out_q   <= '0;
         rx_shift_q    <= '0;
         bit_cnt_q     <= '0;
         byte_done_q   <= 1'b0;
         tx_underrun_q <= 1'b0;
         abort_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_done_q   <= rx_edge && (bit_cnt_q == 3'd7);
         abort_q       <= (state_q == SHIFT) && csb_high && (bit_cnt_q != 3'd0);
         tx_underrun_q <= do_load && !tx_full_q && !tx_valid_i;

         if (do_load) begin
            if (tx_full_q)       shift_out_q <= tx_hold_q;
            else if (tx_valid_i) shift_out_q <= tx_data_i;
            else                 shift_out_q <= TxIdleByte;
         end else if (tx_edge) begin
            shift_out_q <= {shift_out_q[6:0], 1'b0};
         end

         if (do_load && tx_full_q) begin
            tx_full_q <= 1'b0;
         end else if (!do_load && tx_valid_i && !tx_full_q) begin
            tx_hold_q <= tx_data_i;
            tx_full_q <= 1'b1;
         end

         // sd history is the sample taken with the last low sck, i.e. data set up before the edge.
         if (csb_high || do_load) begin
            bit_cnt_q <= '0;
         end else if (rx_edge) begin
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            rx_shift_q <= {rx_shift_q[6:0], sd_q[2]};
         end
      end
   end

`ifdef SPI_DEVICE_LITE_RX_FIFO_EN
   localparam int unsigned PtrW = (RxFifoDepth > 1) ? $clog2(RxFifoDepth) : 1;
   localparam int unsigned CntW = $clog2(RxFifoDepth + 1);

   logic [7:0]      fifo_mem_q [RxFifoDepth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] fifo_cnt_q;
   logic            fifo_wr, fifo_rd;

   assign fifo_rd    = (fifo_cnt_q != '0) && (!rx_valid_q || rx_ready_i);
   assign fifo_wr    = byte_done_q && ((fifo_cnt_q != CntW'(RxFifoDepth)) || fifo_rd);
   assign out_load   = fifo_rd;
   assign out_data   = fifo_mem_q[rd_ptr_q];
   assign overflow_d = byte_done_q && !fifo_wr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (fifo_wr) wr_ptr_q <= (wr_ptr_q == PtrW'(RxFifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
         if (fifo_rd) rd_ptr_q <= (rd_ptr_q == PtrW'(RxFifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
         fifo_cnt_q <= fifo_cnt_q + CntW'(fifo_wr) - CntW'(fifo_rd);
      end
   end

   // NOTE: storage is not reset; clearing the count empties the FIFO and keeps the array RAM-mappable.
   always_ff @(posedge clk_i) begin
      if (fifo_wr) fifo_mem_q[wr_ptr_q] <= rx_shift_q;
   end
`else
   assign out_load   = byte_done_q && (!rx_valid_q || rx_ready_i);
   assign out_data   = rx_shift_q;
   assign overflow_d = byte_done_q && !out_load;

   // RxFifoDepth only sizes the FIFO build.
   if (RxFifoDepth == 0) begin : g_depth_unused
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_valid_q    <= 1'b0;
         rx_data_q     <= '0;
         rx_overflow_q <= 1'b0;
      end else begin
         rx_overflow_q <= overflow_d;
         if (out_load) begin
            rx_data_q  <= out_data;
            rx_valid_q <= 1'b1;
         end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign spi_sd_o      = (state_q != IDLE) && shift_out_q[7];
   assign spi_sd_en_o   = (state_q != IDLE);
   assign busy_o        = (state_q != IDLE);
   assign tx_ready_o    = !tx_full_q;
   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign tx_underrun_o = tx_underrun_q;
   assign rx_overflow_o = rx_overflow_q;
   assign abort_o       = abort_q;
endmodule
